vram_scroller: RTL
==================

// Module: vram_scroller
// PURPOSE
//  Wishbone sequencer for the text video buffer: performs SCROLL, CLEAR and CLEAR_EOL as word
//  transfers on the video adapter's slave port, and arbitrates that port with the host (terminal
//  emulator) path. Sits between the terminal core and the text video adapter on wb_clk_i.
//  Row 0 (service/status line) is never touched by commands.
// PARAMETERS
//  COLS      80      characters per row (even)
//  ROWS      25      rows in buffer, row 0 = service line
//  FILL      8'h20   fill character for cleared cells
//  BASE      16'o0   byte address of buffer on the adapter's bus
// PORTS
//  wb_clk_i     in   1   clock, single domain
//  wb_rst_n     in   1   synchronous reset, active low
//  cmd_start_i  in   1   1-cycle command strobe
//  cmd_i        in   2   0=NOP 1=SCROLL 2=CLEAR 3=CLEAR_EOL
//  cmd_adr_i    in   11  CLEAR_EOL start byte offset (row*COLS+col)
//  busy_o       out  1   command in progress
//  done_o       out  1   1-cycle pulse, command complete
//  err_o        out  1   1-cycle pulse, command rejected
//  s_adr_i/s_dat_i/s_dat_o/s_cyc_i/s_stb_i/s_we_i/s_sel_i/s_ack_o   host slave port, 16/16/16/1/1/1/2/1
//  m_adr_o/m_dat_o/m_dat_i/m_cyc_o/m_stb_o/m_we_o/m_sel_o/m_ack_i   master to adapter, same widths
// BEHAVIOUR
//  Reset: busy_o/done_o/err_o/s_ack_o/m_cyc_o/m_stb_o/m_we_o = 0, m_sel_o = 0, FSM = IDLE.
//   Reset mid-command abandons it at once; no done_o; buffer left partially updated.
//  FSM: IDLE, PASS, RD, WR, FILL, FIN.
//  Master handshake: m_cyc_o = m_stb_o held until m_ack_i is sampled high; both drop on that
//   edge and stay low for one cycle before the next transfer. With a 1-wait slave each transfer
//   is exactly 3 cycles. m_dat_i is captured on the ack edge.
//  IDLE: host request (s_cyc_i&s_stb_i) -> PASS. Host wins when it coincides with cmd_start_i;
//   that command is held pending and starts on the cycle after PASS ends.
//  PASS: s_* forwarded to m_*, s_ack_o = m_ack_i, s_dat_o = m_dat_i; returns to IDLE after ack.
//  While busy_o: host requests stall (s_ack_o=0) until FIN; none lost or reordered.
//  cmd_start_i while busy_o, a pending command already held, NOP, or CLEAR_EOL with
//   cmd_adr_i < COLS or >= ROWS*COLS -> err_o pulse, command ignored, state unchanged.
//  busy_o rises the cycle after an accepted start, falls with the done_o pulse (FIN).
//  Addressing: word index w, m_adr_o = BASE + 2*w, m_sel_o = 2'b11 unless noted.
//  SCROLL: for w = COLS/2 .. (ROWS-1)*COLS/2-1 ascending: RD word w+COLS/2, then WR to w;
//   then FILL w = (ROWS-1)*COLS/2 .. ROWS*COLS/2-1 with {FILL,FILL}.
//  CLEAR: FILL w = COLS/2 .. ROWS*COLS/2-1.
//  CLEAR_EOL: FILL from byte cmd_adr_i through end of its row. Odd start byte: first write
//   m_sel_o=2'b10; the rest use 2'b11.
//  Word counter 10 bits, compared for equality with the end index; no wrap beyond buffer.
//  Total cycles (1-wait slave): SCROLL 3*(2*(ROWS-2)*COLS/2 + COLS/2) = 5640 at defaults;
//   CLEAR 3*(ROWS-1)*COLS/2 = 2880.
// TESTING
//  1 Fill rows with row number; SCROLL -> row r (1..23) = old r+1, row 24 = 0x20, row 0 intact;
//    done_o at cycle 5641 +/-1 after start.
//  2 CLEAR -> bytes 80..1999 = 0x20, bytes 0..79 unchanged; exactly 960 writes, 0 reads.
//  3 CLEAR_EOL adr=165 -> bytes 165..239 = 0x20; byte 164 and 240 unchanged; first m_sel_o=2'b10.
//  4 cmd_start_i with host write in the same cycle -> host acked first, command starts next cycle;
//    host write during SCROLL stalls until done_o, then lands.
//  5 cmd_start_i while busy, CLEAR_EOL adr=40, adr=2000 -> err_o pulse each; no bus activity.
//  6 wb_rst_n low mid-SCROLL -> next cycle m_cyc_o=0, busy_o=0, no done_o; new CLEAR works.

Source files
------------

// File: rtl/vram_scroller.sv
// Wishbone sequencer for the text buffer: SCROLL / CLEAR / CLEAR_EOL as word transfers plus host pass-through.
// One master transfer every 3 cycles against a 1-wait slave; host requests stall (no ack) while a command runs.
module vram_scroller #(
    parameter int          COLS = 80,
    parameter int          ROWS = 25,
    parameter logic [7:0]  FILL = 8'h20,
    parameter logic [15:0] BASE = 16'o0
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n,
    input  logic        cmd_start_i,
    input  logic [1:0]  cmd_i,
    input  logic [10:0] cmd_adr_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    input  logic [15:0] s_adr_i,
    input  logic [15:0] s_dat_i,
    output logic [15:0] s_dat_o,
    input  logic        s_cyc_i,
    input  logic        s_stb_i,
    input  logic        s_we_i,
    input  logic [1:0]  s_sel_i,
    output logic        s_ack_o,
    output logic [15:0] m_adr_o,
    output logic [15:0] m_dat_o,
    input  logic [15:0] m_dat_i,
    output logic        m_cyc_o,
    output logic        m_stb_o,
    output logic        m_we_o,
    output logic [1:0]  m_sel_o,
    input  logic        m_ack_i
);
    typedef enum logic [2:0] {S_IDLE, S_PASS, S_RD, S_WR, S_FILL, S_FIN} state_t;

    localparam logic [1:0]  CMD_NOP    = 2'd0;
    localparam logic [1:0]  CMD_SCROLL = 2'd1;
    localparam logic [1:0]  CMD_EOL    = 2'd3;
    localparam logic [9:0]  W_ROW1     = 10'(COLS / 2);
    localparam logic [9:0]  W_MOVE_END = 10'((ROWS - 1) * COLS / 2 - 1);
    localparam logic [9:0]  W_END      = 10'(ROWS * COLS / 2 - 1);
    localparam logic [10:0] ADR_MIN    = 11'(COLS);
    localparam logic [10:0] ADR_LIM    = 11'(ROWS * COLS);

    // Last word index of the row containing byte offset adr.
    function automatic logic [9:0] eol_last(input logic [10:0] adr);
        int row;
        row = int'(adr) / COLS;
        return 10'((row + 1) * (COLS / 2) - 1);
    endfunction

    state_t      state_q, state_d;
    logic [9:0]  w_q, w_d;
    logic [9:0]  end_q, end_d;
    logic [15:0] dat_q, dat_d;
    logic        stb_q, stb_d;
    logic        odd_q, odd_d;
    logic        pend_q, pend_d;
    logic [1:0]  pend_cmd_q, pend_cmd_d;
    logic [10:0] pend_adr_q, pend_adr_d;
    logic        err_q, err_d;

    logic        busy;
    logic        host_req;
    logic        start_ok;
    logic        launch;
    logic [1:0]  l_cmd;
    logic [10:0] l_adr;
    logic [9:0]  rd_w;

    assign busy     = (state_q == S_RD) || (state_q == S_WR) || (state_q == S_FILL);
    assign host_req = s_cyc_i & s_stb_i;
    assign start_ok = cmd_start_i && !busy && !pend_q && (cmd_i != CMD_NOP) &&
                      !((cmd_i == CMD_EOL) && ((cmd_adr_i < ADR_MIN) || (cmd_adr_i >= ADR_LIM)));
    assign rd_w     = w_q + W_ROW1;

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) begin
            state_q    <= S_IDLE;
            w_q        <= '0;
            end_q      <= '0;
            dat_q      <= '0;
            stb_q      <= 1'b0;
            odd_q      <= 1'b0;
            pend_q     <= 1'b0;
            pend_cmd_q <= '0;
            pend_adr_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            w_q        <= w_d;
            end_q      <= end_d;
            dat_q      <= dat_d;
            stb_q      <= stb_d;
            odd_q      <= odd_d;
            pend_q     <= pend_d;
            pend_cmd_q <= pend_cmd_d;
            pend_adr_q <= pend_adr_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        w_d        = w_q;
        end_d      = end_q;
        dat_d      = dat_q;
        stb_d      = stb_q;
        odd_d      = odd_q;
        pend_d     = pend_q;
        pend_cmd_d = pend_cmd_q;
        pend_adr_d = pend_adr_q;
        err_d      = cmd_start_i & ~start_ok;
        launch     = 1'b0;
        l_cmd      = pend_cmd_q;
        l_adr      = pend_adr_q;

        case (state_q)
            S_IDLE: begin
                if (host_req) begin
                    state_d = S_PASS;
                    if (start_ok) begin
                        pend_d     = 1'b1;
                        pend_cmd_d = cmd_i;
                        pend_adr_d = cmd_adr_i;
                    end
                end else if (pend_q) begin
                    launch = 1'b1;
                end else if (start_ok) begin
                    launch = 1'b1;
                    l_cmd  = cmd_i;
                    l_adr  = cmd_adr_i;
                end
            end
            S_PASS: begin
                if (start_ok) begin
                    pend_d     = 1'b1;
                    pend_cmd_d = cmd_i;
                    pend_adr_d = cmd_adr_i;
                end
                // A held command takes the bus directly when the host cycle ends.
                if (m_ack_i || !s_cyc_i) begin
                    if (pend_q || start_ok) begin
                        launch = 1'b1;
                        if (!pend_q) begin
                            l_cmd = cmd_i;
                            l_adr = cmd_adr_i;
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_RD: begin
                if (!stb_q) begin
                    stb_d = 1'b1;
                end else if (m_ack_i) begin
                    stb_d   = 1'b0;
                    dat_d   = m_dat_i;
                    state_d = S_WR;
                end
            end
            S_WR: begin
                if (!stb_q) begin
                    stb_d = 1'b1;
                end else if (m_ack_i) begin
                    stb_d = 1'b0;
                    w_d   = w_q + 10'd1;
                    if (w_q == W_MOVE_END) begin
                        state_d = S_FILL;
                        end_d   = W_END;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_FILL: begin
                if (!stb_q) begin
                    stb_d = 1'b1;
                end else if (m_ack_i) begin
                    stb_d = 1'b0;
                    odd_d = 1'b0;
                    if (w_q == end_q) state_d = S_FIN;
                    else              w_d     = w_q + 10'd1;
                end
            end
            S_FIN: begin
                if (start_ok) begin
                    pend_d     = 1'b1;
                    pend_cmd_d = cmd_i;
                    pend_adr_d = cmd_adr_i;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // First transfer of a command always follows a one-cycle idle gap.
        if (launch) begin
            pend_d = 1'b0;
            stb_d  = 1'b0;
            w_d    = W_ROW1;
            end_d  = W_END;
            odd_d  = 1'b0;
            case (l_cmd)
                CMD_SCROLL: state_d = S_RD;
                CMD_EOL: begin
                    state_d = S_FILL;
                    w_d     = l_adr[10:1];
                    end_d   = eol_last(l_adr);
                    odd_d   = l_adr[0];
                end
                default: state_d = S_FILL;
            endcase
        end
    end

    always_comb begin
        busy_o  = busy;
        done_o  = (state_q == S_FIN);
        err_o   = err_q;
        s_dat_o = '0;
        s_ack_o = 1'b0;
        m_adr_o = '0;
        m_dat_o = '0;
        m_cyc_o = 1'b0;
        m_stb_o = 1'b0;
        m_we_o  = 1'b0;
        m_sel_o = 2'b00;
        case (state_q)
            S_PASS: begin
                m_adr_o = s_adr_i;
                m_dat_o = s_dat_i;
                m_cyc_o = s_cyc_i;
                m_stb_o = s_stb_i;
                m_we_o  = s_we_i;
                m_sel_o = s_sel_i;
                s_ack_o = m_ack_i;
                s_dat_o = m_dat_i;
            end
            S_RD: begin
                m_adr_o = BASE + {5'd0, rd_w, 1'b0};
                m_cyc_o = stb_q;
                m_stb_o = stb_q;
                m_sel_o = 2'b11;
            end
            S_WR: begin
                m_adr_o = BASE + {5'd0, w_q, 1'b0};
                m_dat_o = dat_q;
                m_cyc_o = stb_q;
                m_stb_o = stb_q;
                m_we_o  = 1'b1;
                m_sel_o = 2'b11;
            end
            S_FILL: begin
                m_adr_o = BASE + {5'd0, w_q, 1'b0};
                m_dat_o = {FILL, FILL};
                m_cyc_o = stb_q;
                m_stb_o = stb_q;
                m_we_o  = 1'b1;
                m_sel_o = odd_q ? 2'b10 : 2'b11;
            end
            default: ;
        endcase
    end
endmodule
